column_solver: RTL

Parametrised 1-D wave-equation column solver: the second-generation column engine for the drum/string simulation. It holds u(n) and u(n-1) for NUM_ROW nodes in two M10K-style RAMs, has an external initial-condition load port, and runs one time step per start, or runs continuously. Fixed (zero) boundaries, run-time damping, saturating arithmetic and a selectable output tap row. It is the drop-in per-column unit that the later multi-column array will instantiate.

---
 rtl/column_solver.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/column_solver.sv
// column_solver: one column of a 1-D wave-equation solver.
// The block keeps u(n) and u(n-1) for NUM_ROW nodes in two synchronous-read RAMs.
// Each step sweeps the rows in order and produces u(n+1) with fixed zero
// boundaries, optional damping and saturation.
//
// start/busy handshake: start is a request that is taken only in the cycle it
// is seen high while the block is idle (busy low) and init_we is low. busy rises
// on the following cycle and stays high until the step_done cycle, inclusive.
// In continuous mode busy stays high across back-to-back steps. A request that
// arrives while busy is high is dropped, not queued.
module column_solver #(
  parameter int NUM_ROW = 33,
  parameter int ADDR_W  = 6,
  parameter int DW      = 18,
  parameter int FRAC    = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DW-1:0]     rho,
  input  logic [3:0]        eta_shift,
  input  logic              run_cont,
  input  logic              start,
  input  logic              init_we,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DW-1:0]     init_data,
  input  logic [ADDR_W-1:0] tap_row,
  output logic              busy,
  output logic              step_done,
  output logic [DW-1:0]     tap_out,
  output logic              tap_valid,
  output logic [15:0]       step_cnt,
  output logic [2:0]        dbg_state
);

  localparam int W     = DW + 3;
  localparam int PW    = 2 * DW + 3;
  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [ADDR_W:0]   NUM_ROW_W = (ADDR_W + 1)'(NUM_ROW);
  localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(NUM_ROW - 1);
  localparam logic signed [W-1:0] SAT_MAX = {{(W - DW + 1){1'b0}}, {(DW - 1){1'b1}}};
  localparam logic signed [W-1:0] SAT_MIN = {{(W - DW + 1){1'b1}}, {(DW - 1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRIME = 3'd1,
    S_CALC  = 3'd2,
    S_FETCH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   row;
  logic [DW-1:0]       rho_q;
  logic [3:0]          eta_q;
  logic [ADDR_W-1:0]   tap_q;
  logic [DW-1:0]       u_prev;
  logic [DW-1:0]       centre;

  // RAM storage and registered read data
  logic [DW-1:0]       un_mem  [DEPTH];
  logic [DW-1:0]       nm1_mem [DEPTH];
  logic [DW-1:0]       un_rd_r;
  logic [DW-1:0]       un_rd_c;
  logic [DW-1:0]       nm1_rd;

  logic [ADDR_W-1:0]   un_ra_r;
  logic [ADDR_W-1:0]   nm1_ra;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_wa;
  logic [DW-1:0]       un_wd;
  logic [DW-1:0]       nm1_wd;

  logic [DW-1:0]       u_c;
  logic [DW-1:0]       u_jp1;
  logic [DW-1:0]       u_np1;
  logic signed [W-1:0] u_e, jm1_e, jp1_e, nm1_e;
  logic signed [W-1:0] lap, a_term, nm1_d, s_val, s_d;
  logic signed [PW-1:0] prod;
  logic                unused_prod;

  assign dbg_state = state;

  // Read addresses: PRIME fetches the right neighbour of row 0, FETCH the next row's operands
  always_comb begin
    un_ra_r = row + ADDR_W'(1);
    nm1_ra  = row;
    if (state == S_PRIME) begin
      un_ra_r = ADDR_W'(1);
      nm1_ra  = '0;
    end
  end

  // Write port: the init load in IDLE, the result write-back in CALC; nothing while in reset
  always_comb begin
    ram_we = 1'b0;
    ram_wa = row;
    un_wd  = u_np1;
    nm1_wd = u_c;
    if (rst_n) begin
      if (state == S_IDLE && init_we && ({1'b0, init_addr} < NUM_ROW_W)) begin
        ram_we = 1'b1;
        ram_wa = init_addr;
        un_wd  = init_data;
        nm1_wd = init_data;
      end else if (state == S_CALC) begin
        ram_we = 1'b1;
      end
    end
  end

  // Two RAMs with one write port and registered reads; contents are never reset
  always_ff @(posedge clk) begin
    if (ram_we) begin
      un_mem[ram_wa]  <= un_wd;
      nm1_mem[ram_wa] <= nm1_wd;
    end
    un_rd_r <= un_mem[un_ra_r];
    un_rd_c <= un_mem[0];
    nm1_rd  <= nm1_mem[nm1_ra];
  end

  // Node update: Laplacian, coefficient multiply, leapfrog with damping, saturation
  always_comb begin
    u_c    = (row == '0) ? un_rd_c : centre;
    u_jp1  = (row == LAST_ROW) ? '0 : un_rd_r;
    u_e    = {{(W - DW){u_c[DW-1]}}, u_c};
    jm1_e  = {{(W - DW){u_prev[DW-1]}}, u_prev};
    jp1_e  = {{(W - DW){u_jp1[DW-1]}}, u_jp1};
    nm1_e  = {{(W - DW){nm1_rd[DW-1]}}, nm1_rd};
    lap    = jm1_e + jp1_e - (u_e <<< 1);
    prod   = $signed({{(PW - DW){1'b0}}, rho_q}) * $signed({{(PW - W){lap[W-1]}}, lap});
    a_term = prod[FRAC +: W];
    nm1_d  = (eta_q == 4'd0) ? nm1_e : nm1_e - (nm1_e >>> eta_q);
    s_val  = (u_e <<< 1) + a_term - nm1_d;
    s_d    = (eta_q == 4'd0) ? s_val : s_val - (s_val >>> eta_q);
    if (s_d > SAT_MAX) begin
      u_np1 = SAT_MAX[DW-1:0];
    end else if (s_d < SAT_MIN) begin
      u_np1 = SAT_MIN[DW-1:0];
    end else begin
      u_np1 = s_d[DW-1:0];
    end
  end

  // Bits of the product that the arithmetic shift and the truncation discard
  assign unused_prod = ^{prod[PW-1:FRAC+W], prod[FRAC-1:0]};

  // Step sequencer with registered status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      row       <= '0;
      rho_q     <= '0;
      eta_q     <= '0;
      tap_q     <= '0;
      u_prev    <= '0;
      centre    <= '0;
      busy      <= 1'b0;
      step_done <= 1'b0;
      tap_out   <= '0;
      tap_valid <= 1'b0;
      step_cnt  <= '0;
    end else begin
      step_done <= 1'b0;
      tap_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !init_we) begin
            rho_q <= rho;
            eta_q <= eta_shift;
            tap_q <= tap_row;
            row   <= '0;
            busy  <= 1'b1;
            state <= S_PRIME;
          end
        end
        S_PRIME: begin
          u_prev <= '0;
          state  <= S_CALC;
        end
        S_CALC: begin
          u_prev <= u_c;
          centre <= u_jp1;
          if (row == tap_q) begin
            tap_out   <= u_np1;
            tap_valid <= 1'b1;
          end
          if (row == LAST_ROW) begin
            step_done <= 1'b1;
            step_cnt  <= step_cnt + 16'd1;
            state     <= S_DONE;
          end else begin
            row   <= row + ADDR_W'(1);
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          state <= S_CALC;
        end
        S_DONE: begin
          row <= '0;
          if (run_cont) begin
            state <= S_PRIME;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
